// File: rtl/grf_pkg.sv
// Shared definitions for the multi-port register file: sizing helper,
// packed-port slicing and the write trace format.
package grf_pkg;

   localparam int PK_MAX = 256;
   localparam string TRACE_FMT = "%d@%h: $%d <= %h";

   function automatic int nregs_of(input int aw);
      return 1 << aw;
   endfunction

   // Field k of width w from a packed multi-port vector (zero-extended to PK_MAX)
   function automatic logic [PK_MAX-1:0] port_slice(input logic [PK_MAX-1:0] vec,
                                                    input int k, input int w);
      logic [PK_MAX-1:0] m;
      m = {PK_MAX{1'b1}} >> (PK_MAX - w);
      return (vec >> (k * w)) & m;
   endfunction

endpackage

// File: rtl/grf_sb_cnt.sv
// Pending-writer counter for one register: up on issue, down by up to two
// retires, clamped to [0, 2**CNT_W-1], cleared by flush.
module grf_sb_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic [1:0]       dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   localparam int SW = CNT_W + 2;

   logic [SW-1:0] sum, nxt, cmax;

   assign cmax = SW'({CNT_W{1'b1}});

   always_comb begin
      sum = SW'(cnt) + SW'(inc);
      if (sum < SW'(dec)) nxt = '0;
      else                nxt = sum - SW'(dec);
      if (nxt > cmax)     nxt = cmax;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   cnt <= '0;
      else if (clr) cnt <= '0;
      else          cnt <= CNT_W'(nxt);
   end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file: NRD forwarding read ports, two ordered
// write ports (W1 younger) and a per-register pending-write scoreboard.
module grf_mp
   import grf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 3,
   parameter int CNT_W  = 2,
   parameter int TRACE  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  w0_en,
   input  logic [ADDR_W-1:0]     w0_addr,
   input  logic [DATA_W-1:0]     w0_data,
   input  logic [31:0]           w0_pc,
   input  logic                  w1_en,
   input  logic [ADDR_W-1:0]     w1_addr,
   input  logic [DATA_W-1:0]     w1_data,
   input  logic [31:0]           w1_pc,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  iss_ready,
   input  logic                  flush
);

   localparam int NREGS = nregs_of(ADDR_W);
   localparam int BW    = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                         w0_act, w1_act;
   logic [NREGS-1:0][DATA_W-1:0] regs;
   logic [NREGS-1:0][CNT_W-1:0]  cnt;
   logic [NREGS-1:0][1:0]        dec;
   logic [PK_MAX-1:0]            rd_addr_ext;

   // Reset blocks writes, so neither forwarding nor retires happen under it
   assign w0_act      = w0_en & reset;
   assign w1_act      = w1_en & reset;
   assign rd_addr_ext = PK_MAX'(rd_addr);

   assign cnt[0] = '0;
   assign dec[0] = '0;

   // A retire to a saturated register frees a slot in the same cycle
   assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != CNT_MAX) || (dec[iss_addr] != 2'd0);

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      logic h0, h1, inc;
      assign h0     = w0_act && (w0_addr == ADDR_W'(r));
      assign h1     = w1_act && (w1_addr == ADDR_W'(r));
      assign dec[r] = {h0 & h1, h0 ^ h1};
      assign inc    = iss_valid && iss_ready && !flush && (iss_addr == ADDR_W'(r));

      grf_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (inc),
         .dec   (dec[r]),
         .clr   (flush),
         .cnt   (cnt[r])
      );
   end

   // W1 assigned last so it wins a same-address collision
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs <= '0;
      end else begin
         if (w0_en && w0_addr != '0) regs[w0_addr] <= w0_data;
         if (w1_en && w1_addr != '0) regs[w1_addr] <= w1_data;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;

      assign a = ADDR_W'(port_slice(rd_addr_ext, k, ADDR_W));

      always_comb begin
         if (a == '0)                      d = '0;
         else if (w1_act && w1_addr == a)  d = w1_data;
         else if (w0_act && w0_addr == a)  d = w0_data;
         else                              d = regs[a];
      end

      assign rd_data[k*DATA_W +: DATA_W] = d;
      assign rd_busy[k] = (a != '0) && (BW'(cnt[a]) > BW'(dec[a]));
   end

`ifndef SYNTHESIS
   if (TRACE != 0) begin : g_trace
      always_ff @(posedge clk) begin
         if (reset && w0_en && w0_addr != '0)
            $display("%s", $sformatf(TRACE_FMT, $time, w0_pc, w0_addr, w0_data));
         if (reset && w1_en && w1_addr != '0)
            $display("%s", $sformatf(TRACE_FMT, $time, w1_pc, w1_addr, w1_data));
      end
   end
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp: expectations are queued as stimulus is driven
// and popped against the DUT outputs a couple of time units later.
module tb_grf_mp;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*DW-1:0]   rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                w0_en, w1_en;
   logic [AW-1:0]       w0_addr, w1_addr;
   logic [DW-1:0]       w0_data, w1_data;
   logic [31:0]         w0_pc, w1_pc;
   logic                iss_valid;
   logic [AW-1:0]       iss_addr;
   logic                iss_ready;
   logic                flush;

   grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .CNT_W(2), .TRACE(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .w0_en     (w0_en),
      .w0_addr   (w0_addr),
      .w0_data   (w0_data),
      .w0_pc     (w0_pc),
      .w1_en     (w1_en),
      .w1_addr   (w1_addr),
      .w1_data   (w1_data),
      .w1_pc     (w1_pc),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .flush     (flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [95:0]  v;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miss    = 0;

   task automatic push(input string tag, input logic [95:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sbq.push_back(e);
   endtask

   task automatic pop_chk(input logic [95:0] obs);
      exp_t e;
      vectors++;
      if (sbq.size() == 0) begin
         miss++;
         $error("FAIL scoreboard_empty: got %h, nothing expected", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.v) else begin
            miss++;
            $error("FAIL %s: got %h want %h", e.tag, obs, e.v);
         end
      end
   endtask

   function automatic logic [95:0] rdd(input int k);
      return 96'(rd_data[k*DW +: DW]);
   endfunction

   function automatic logic [NRD*AW-1:0] ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                            input logic [AW-1:0] a2);
      return {a2, a1, a0};
   endfunction

   task automatic idle();
      w0_en = 1'b0; w1_en = 1'b0; iss_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      idle();
      w0_addr = '0; w0_data = '0; w0_pc = 32'h0;
      w1_addr = '0; w1_data = '0; w1_pc = 32'h0;
      iss_addr = '0;
      rd_addr = ra(5'd5, 5'd6, 5'd0);

      // reset state
      edge_();
      push("reset_rd_data", 96'd0);
      push("reset_rd_busy", 96'd0);
      push("reset_iss_ready_r0", 96'd1);
      #1;
      pop_chk(rd_data); pop_chk(96'(rd_busy)); pop_chk(96'(iss_ready));
      reset = 1'b1;
      edge_();

      // write r5 with forwarding, issue r6
      w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'h1234; w0_pc = 32'h100;
      iss_valid = 1'b1; iss_addr = 5'd6;
      push("fwd_r5", 96'h1234);
      push("busy_r6_pre", 96'd0);
      #2;
      pop_chk(rdd(0)); pop_chk(96'(rd_busy));
      edge_();
      idle();
      push("stored_r5", 96'h1234);
      push("busy_r6", 96'd2);
      #2;
      pop_chk(rdd(0)); pop_chk(96'(rd_busy));

      // asynchronous reset mid-cycle
      reset = 1'b0;
      push("async_rst_data", 96'd0);
      push("async_rst_busy", 96'd0);
      #1;
      pop_chk(rd_data); pop_chk(96'(rd_busy));
      #1 reset = 1'b1;
      edge_();
      push("post_rst_r5", 96'd0);
      push("post_rst_busy", 96'd0);
      #2;
      pop_chk(rdd(0)); pop_chk(96'(rd_busy));

      // W0 write r3 with same-cycle read
      edge_();
      rd_addr = ra(5'd3, 5'd0, 5'd0);
      w0_en = 1'b1; w0_addr = 5'd3; w0_data = 32'hA5A5A5A5; w0_pc = 32'h104;
      push("fwd_r3", 96'hA5A5A5A5);
      #2 pop_chk(rdd(0));
      edge_();
      idle();
      push("stored_r3", 96'hA5A5A5A5);
      #2 pop_chk(rdd(0));

      // both ports write r7: W1 wins
      edge_();
      rd_addr = ra(5'd7, 5'd3, 5'd0);
      w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'h11; w0_pc = 32'h108;
      w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h22; w1_pc = 32'h10C;
      push("fwd_r7_w1", 96'h22);
      #2 pop_chk(rdd(0));
      edge_();
      idle();
      push("stored_r7_w1", 96'h22);
      #2 pop_chk(rdd(0));

      // saturate r4 with three issues
      rd_addr = ra(5'd7, 5'd4, 5'd0);
      for (int i = 0; i < 3; i++) begin
         iss_valid = 1'b1; iss_addr = 5'd4;
         push($sformatf("iss_ready_r4_%0d", i), 96'd1);
         #2 pop_chk(96'(iss_ready));
         edge_();
      end
      push("iss_ready_r4_sat", 96'd0);
      push("busy_r4_sat", 96'd2);
      #2;
      pop_chk(96'(iss_ready)); pop_chk(96'(rd_busy));
      edge_();
      iss_valid = 1'b0;
      w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'h44; w0_pc = 32'h110;
      push("busy_r4_ret1", 96'd2);
      push("iss_ready_r4_ret", 96'd1);
      #2;
      pop_chk(96'(rd_busy)); pop_chk(96'(iss_ready));
      edge_();
      push("busy_r4_ret2", 96'd2);
      #2 pop_chk(96'(rd_busy));
      edge_();
      w0_data = 32'h45;
      push("busy_r4_ret3", 96'd0);
      push("fwd_r4", 96'h45);
      #2;
      pop_chk(96'(rd_busy)); pop_chk(rdd(1));
      edge_();
      idle();
      push("busy_r4_after", 96'd0);
      push("stored_r4", 96'h45);
      #2;
      pop_chk(96'(rd_busy)); pop_chk(rdd(1));

      // issue and retire r9 in the same cycle
      rd_addr = ra(5'd7, 5'd4, 5'd9);
      iss_valid = 1'b1; iss_addr = 5'd9;
      edge_();
      w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h99; w1_pc = 32'h114;
      push("busy_r9_iss_ret", 96'd0);
      #2 pop_chk(96'(rd_busy));
      edge_();
      idle();
      push("busy_r9_held", 96'd4);
      #2 pop_chk(96'(rd_busy));
      w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h9A;
      edge_();
      idle();
      push("busy_r9_clear", 96'd0);
      #2 pop_chk(96'(rd_busy));

      // flush with pending issue and a concurrent write
      rd_addr = ra(5'd2, 5'd3, 5'd0);
      iss_valid = 1'b1; iss_addr = 5'd2;
      edge_();
      edge_();
      push("busy_r2_cnt2", 96'd1);
      #2 pop_chk(96'(rd_busy));
      flush = 1'b1;
      w0_en = 1'b1; w0_addr = 5'd3; w0_data = 32'h3333; w0_pc = 32'h118;
      edge_();
      idle();
      push("busy_after_flush", 96'd0);
      push("flush_write_kept", 96'h3333);
      #2;
      pop_chk(96'(rd_busy)); pop_chk(rdd(1));

      // register 0 is hardwired
      rd_addr = ra(5'd0, 5'd3, 5'd0);
      w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'hFFFF; w0_pc = 32'h11C;
      iss_valid = 1'b1; iss_addr = 5'd0;
      push("r0_fwd", 96'd0);
      push("r0_busy", 96'd0);
      push("r0_iss_ready", 96'd1);
      #2;
      pop_chk(rdd(0)); pop_chk(96'(rd_busy)); pop_chk(96'(iss_ready));
      edge_();
      idle();
      push("r0_stored", 96'd0);
      push("r0_busy_after", 96'd0);
      #2;
      pop_chk(rdd(0)); pop_chk(96'(rd_busy));

      if (sbq.size() != 0) begin
         miss++;
         $error("FAIL scoreboard_leftover: got %0d entries want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

endmodule
